// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters and perf counters.
// Latency: lookup is combinational (0 cycles); updates and stats commit at the next rising edge.
// Backpressure: none; one resolved branch is accepted every cycle, flush drops a same-cycle update.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   lk_pc_i,
  output logic              lk_hit_o,
  output logic              lk_taken_o,
  output logic [XLEN-1:0]   lk_target_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [XLEN-1:0]   upd_pred_target_i,
  output logic              mispredict_o,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + 2 + TAG_W - 1;

  // Weakly not-taken (01..1) is the reset/flush value; weakly taken (10..0) is the allocation value.
  localparam logic [CNT_W-1:0]  CNT_WNT  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_WT   = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];

  logic [STAT_W-1:0] r_stat_br;
  logic [STAT_W-1:0] r_stat_mp;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_lk_hit;
  logic             w_upd_hit;
  logic             w_unused_pc_bits;

  assign w_lk_idx  = lk_pc_i[IDX_W+1:2];
  assign w_lk_tag  = lk_pc_i[TAG_HI:TAG_LO];
  assign w_upd_idx = upd_pc_i[IDX_W+1:2];
  assign w_upd_tag = upd_pc_i[TAG_HI:TAG_LO];

  // Byte offset and PC bits above the tag take no part in indexing or matching.
  assign w_unused_pc_bits = ^{lk_pc_i[1:0], lk_pc_i[XLEN-1:TAG_HI+1],
                              upd_pc_i[1:0], upd_pc_i[XLEN-1:TAG_HI+1]};

  // Lookup reads the registered table only, so a same-cycle update is never bypassed.
  always_comb begin
    w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    lk_hit_o    = w_lk_hit;
    lk_taken_o  = w_lk_hit && r_cnt[w_lk_idx][CNT_W-1];
    lk_target_o = w_lk_hit ? r_target[w_lk_idx] : '0;
  end

  // Wrong direction, or right "taken" direction with the wrong target.
  assign mispredict_o = upd_valid_i &&
                        ((upd_pred_taken_i != upd_taken_i) ||
                         (upd_taken_i && (upd_pred_target_i != upd_target_i)));

  // Table update: flush beats update; a not-taken miss does not allocate.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CNT_WNT;
      end
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_WNT;
      end
    end else if (upd_valid_i) begin
      if (w_upd_hit) begin
        if (upd_taken_i) begin
          if (r_cnt[w_upd_idx] != CNT_MAX) r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + CNT_ONE;
          r_target[w_upd_idx] <= upd_target_i;
        end else begin
          if (r_cnt[w_upd_idx] != CNT_ZERO) r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - CNT_ONE;
        end
      end else if (upd_taken_i) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target_i;
        r_cnt[w_upd_idx]    <= CNT_WT;
      end
    end
  end

  // Saturating perf counters; they count every resolved branch, flushed or not.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (upd_valid_i) begin
      if (r_stat_br != STAT_MAX) r_stat_br <= r_stat_br + STAT_ONE;
      if (mispredict_o && (r_stat_mp != STAT_MAX)) r_stat_mp <= r_stat_mp + STAT_ONE;
    end
  end

  assign stat_branches_o = r_stat_br;
  assign stat_mispred_o  = r_stat_mp;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: default-width instance plus a STAT_W=4 instance
// sharing the same stimulus for the counter saturation case.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic [31:0] lk_pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;

  logic        lk_hit_o, lk_taken_o, mispredict_o;
  logic [31:0] lk_target_o;
  logic [15:0] stat_branches_o, stat_mispred_o;

  logic        s_hit, s_taken, s_mp;
  logic [31:0] s_target;
  logic [3:0]  s_br, s_mpc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  branch_predictor dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .lk_pc_i(lk_pc_i),
    .lk_hit_o(lk_hit_o), .lk_taken_o(lk_taken_o), .lk_target_o(lk_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .mispredict_o(mispredict_o),
    .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
  );

  branch_predictor #(.STAT_W(4)) dut_s4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .lk_pc_i(lk_pc_i),
    .lk_hit_o(s_hit), .lk_taken_o(s_taken), .lk_target_o(s_target),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .mispredict_o(s_mp),
    .stat_branches_o(s_br), .stat_mispred_o(s_mpc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic hit, input logic tk, input logic [31:0] tgt);
    lk_pc_i = pc;
    #1;
    chk({tag, " hit"},    {31'd0, lk_hit_o},   {31'd0, hit});
    chk({tag, " taken"},  {31'd0, lk_taken_o}, {31'd0, tk});
    chk({tag, " target"}, lk_target_o,         tgt);
  endtask

  // Present one resolved branch and check the combinational mispredict flag.
  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt, input logic exp_mp);
    upd_valid_i       = 1'b1;
    upd_pc_i          = pc;
    upd_taken_i       = tk;
    upd_target_i      = tgt;
    upd_pred_taken_i  = ptk;
    upd_pred_target_i = ptgt;
    #1;
    chk("mispredict", {31'd0, mispredict_o}, {31'd0, exp_mp});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt, input logic exp_mp);
    drive_upd(pc, tk, tgt, ptk, ptgt, exp_mp);
    tick();
  endtask

  task automatic stats(input string tag, input logic [15:0] br, input logic [15:0] mp);
    chk({tag, " branches"}, {16'd0, stat_branches_o}, {16'd0, br});
    chk({tag, " mispred"},  {16'd0, stat_mispred_o},  {16'd0, mp});
  endtask

  initial begin
    rst_n_i = 1'b0; flush_i = 1'b0; lk_pc_i = 32'h40;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
    upd_pred_taken_i = 1'b0; upd_pred_target_i = '0;
    #2;
    look("reset", 32'h40, 1'b0, 1'b0, 32'h0);
    stats("reset", 16'd0, 16'd0);
    #10 rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // First taken branch allocates weakly taken; lookup is not bypassed in the same cycle.
    drive_upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
    look("no bypass", 32'h40, 1'b0, 1'b0, 32'h0);
    tick();
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h20);
    stats("alloc", 16'd1, 16'd1);

    // Right direction, wrong target is a mispredict; counter climbs to 11.
    upd(32'h40, 1'b1, 32'h20, 1'b1, 32'h24, 1'b1);
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0);
    look("cnt11", 32'h40, 1'b1, 1'b1, 32'h20);

    // Two not-taken: 11 -> 10 -> 01, target untouched by a not-taken update.
    for (int i = 0; i < 2; i++) upd(32'h40, 1'b0, 32'h99, 1'b1, 32'h20, 1'b1);
    look("cnt01", 32'h40, 1'b1, 1'b0, 32'h20);
    upd(32'h40, 1'b0, 32'h99, 1'b1, 32'h20, 1'b1);
    look("cnt00", 32'h40, 1'b1, 1'b0, 32'h20);
    upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
    look("cnt00->01", 32'h40, 1'b1, 1'b0, 32'h20);
    upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
    look("cnt01->10", 32'h40, 1'b1, 1'b1, 32'h20);
    stats("after 0x40", 16'd10, 16'd7);

    // Not-taken miss does not allocate; taken alias at the same index replaces 0x40.
    upd(32'h80, 1'b0, 32'h30, 1'b0, 32'h0, 1'b0);
    look("nt miss", 32'h80, 1'b0, 1'b0, 32'h0);
    look("0x40 kept", 32'h40, 1'b1, 1'b1, 32'h20);
    upd(32'h80, 1'b1, 32'h30, 1'b0, 32'h0, 1'b1);
    look("evicted", 32'h40, 1'b0, 1'b0, 32'h0);
    look("0x80 alloc", 32'h80, 1'b1, 1'b1, 32'h30);

    // Same-cycle lookup and update of one entry: lookup sees the old counter.
    lk_pc_i = 32'h80;
    drive_upd(32'h80, 1'b0, 32'h30, 1'b1, 32'h30, 1'b1);
    look("same cycle", 32'h80, 1'b1, 1'b1, 32'h30);
    tick();
    look("after same cycle", 32'h80, 1'b1, 1'b0, 32'h30);
    stats("pre flush", 16'd13, 16'd9);

    // Flush drops the update but the stats still count it.
    drive_upd(32'h80, 1'b1, 32'h44, 1'b1, 32'h30, 1'b1);
    flush_i = 1'b1;
    tick();
    look("flushed", 32'h80, 1'b0, 1'b0, 32'h0);
    stats("flush", 16'd14, 16'd10);

    // Asynchronous reset clears outputs before any clock edge.
    upd(32'h40, 1'b1, 32'h50, 1'b0, 32'h0, 1'b1);
    look("pre reset", 32'h40, 1'b1, 1'b1, 32'h50);
    rst_n_i = 1'b0;
    look("async reset", 32'h40, 1'b0, 1'b0, 32'h0);
    stats("async reset", 16'd0, 16'd0);
    chk("async reset s4 branches", {28'd0, s_br}, 32'd0);
    #2 rst_n_i = 1'b1;

    // 17 mispredicted branches: 16-bit counters reach 17, 4-bit counters hold at 15.
    for (int i = 0; i < 17; i++) upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    stats("sat16", 16'd17, 16'd17);
    chk("sat4 branches", {28'd0, s_br},  32'd15);
    chk("sat4 mispred",  {28'd0, s_mpc}, 32'd15);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
